sd_cmd_send: RTL and testbench
==============================

Name: sd_cmd_send

Overview:
Command-path transmitter that sits directly upstream of the SD response receiver. It frames a 48-bit SD command: start bit 0, transmission bit 1, 6-bit index, 32-bit argument, CRC7 and end bit 1. It computes the CRC7 serially and shifts the frame out MSB-first on the CMD line at a divided bit rate. On completion it pulses the receiver's enable so response capture can begin.

Parameters:
CLK_DIV, 4, ex_clk cycles per CMD bit; legal range 1..255.

Ports:
ex_clk  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
send_en  input  1  start request; sampled only in IDLE
cmd_index  input  6  command index, latched at acceptance
cmd_arg  input  32  command argument, latched at acceptance
expect_response  input  1  latched at acceptance; selects whether receive_en fires
sd_cmd_out  output  1  serial CMD data
sd_cmd_oe  output  1  CMD line drive enable; 1 only while a frame is driven
busy  output  1  high from acceptance until the finished pulse, inclusive
sd_send_finished  output  1  one-cycle pulse after the end bit completes
receive_en  output  1  one-cycle pulse with sd_send_finished when expect_response was 1
crc_out  output  7  CRC7 of the last frame; valid from the finished pulse until the next acceptance

Behaviour:
- Reset values (async, immediate): sd_cmd_out=1, sd_cmd_oe=0, busy=0, sd_send_finished=0, receive_en=0, crc_out=0. State returns to IDLE.
- Reset asserted mid-frame aborts the frame with no finished pulse. Outputs take their reset values immediately.
- States:
  - IDLE: if send_en=1, latch the inputs into a 40-bit shift register {0,1,index,arg}, clear the CRC register and bit counter, and go to DATA. Otherwise stay in IDLE.
  - DATA: drive register MSB for CLK_DIV cycles. On the last cycle of each bit, advance the CRC with that bit and shift the register. After 40 bits go to CRC.
  - CRC: drive CRC bits MSB-first (bit 6 first), CLK_DIV cycles each. After 7 bits go to STOP.
  - STOP: drive 1 for CLK_DIV cycles, then go to DONE.
  - DONE: for exactly one cycle, set oe=0 and out=1, pulse sd_send_finished, pulse receive_en if the latched expect_response=1, and hold busy=1. Then go to IDLE.
- Timing:
  - sd_cmd_oe rises in the cycle after acceptance and stays high for exactly 48*CLK_DIV cycles.
  - The finished pulse occurs 48*CLK_DIV+1 cycles after acceptance.
  - Minimum acceptance-to-acceptance spacing is 48*CLK_DIV+2 cycles.
- CRC7: polynomial x^7+x^3+1, initial value 0. Per bit: fb = d ^ crc[6]; crc = {crc[5:3], crc[2]^fb, crc[1:0], fb}. The CRC covers only the first 40 bits.
- The bit-tick divider counts 0..CLK_DIV-1. When CLK_DIV=1, every cycle is a bit boundary.
- send_en while busy is ignored and not queued. Input changes after acceptance have no effect on the frame in progress.
- send_en=1 in the same cycle as the DONE pulse is ignored. It is accepted only if still high on the following IDLE cycle.

Test Plan:
1. CLK_DIV=1, CMD0 (index 0, arg 0, expect_response=0) -> serial frame 0x40_00000000_95; crc_out=0x4A; finished pulse 49 cycles after acceptance; receive_en stays 0.
2. CLK_DIV=4, CMD8 arg 0x000001AA, expect_response=1 -> frame 0x48_000001AA_87; crc_out=0x43; each bit held exactly 4 cycles; oe high for 192 cycles; receive_en and finished pulse together once.
3. CLK_DIV=2, CMD17 arg 0 -> frame 0x51_00000000_55; crc_out=0x2A. Pulsing send_en and toggling cmd_arg mid-frame causes no frame change and no second frame.
4. Assert reset at bit 20 of a frame -> oe=0 and out=1 in the same cycle; no finished pulse. A new send_en after release transmits a full correct frame.
5. Back-to-back: hold send_en high continuously with CLK_DIV=1 -> two identical frames, with the second acceptance 50 cycles after the first; oe low for exactly 2 cycles between frames.

Source files
------------

// File: rtl/sd_cmd_send.sv
// sd_cmd_send: SD command-line transmitter.
// Frames a 48-bit SD command {0, 1, index[5:0], arg[31:0], crc7[6:0], 1}.
// It computes CRC7 serially over the first 40 bits and shifts the frame out
// MSB-first, holding each bit for CLK_DIV ex_clk cycles. When the end bit has
// been sent it pulses sd_send_finished, and also receive_en when a response is
// expected, so the response receiver can start capturing.
//
// Ports:
//   ex_clk           system clock, rising edge
//   reset            asynchronous active-high reset
//   send_en          start request, sampled only while idle
//   cmd_index        command index, latched when the request is accepted
//   cmd_arg          command argument, latched when the request is accepted
//   expect_response  latched when the request is accepted; gates receive_en
//   sd_cmd_out       serial CMD data (idles high)
//   sd_cmd_oe        CMD drive enable, high only while the frame is driven
//   busy             high from acceptance through the finished pulse
//   sd_send_finished one-cycle pulse after the end bit
//   receive_en       one-cycle pulse with sd_send_finished if a response is expected
//   crc_out          CRC7 of the last frame, valid from the finished pulse on
module sd_cmd_send #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic        ex_clk,
    input  logic        reset,
    input  logic        send_en,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic        expect_response,
    output logic        sd_cmd_out,
    output logic        sd_cmd_oe,
    output logic        busy,
    output logic        sd_send_finished,
    output logic        receive_en,
    output logic [6:0]  crc_out
);

    localparam int unsigned DIV_W     = 8;
    localparam int unsigned PAYLOAD_W = 40;
    localparam int unsigned CRC_W     = 7;
    localparam int unsigned CNT_W     = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_CRC,
        S_STOP,
        S_DONE
    } state_t;

    state_t               state;
    logic [PAYLOAD_W-1:0] shift_reg;
    logic [CRC_W-1:0]     crc_reg;
    logic [CRC_W-1:0]     crc_sh;
    logic [CNT_W-1:0]     bit_cnt;
    logic [DIV_W-1:0]     div_cnt;
    logic                 expect_q;

    logic                 bit_tick_c;
    logic [CRC_W-1:0]     crc_next_c;

    // One CRC7 step, polynomial x^7 + x^3 + 1.
    function automatic logic [CRC_W-1:0] crc7_step(input logic [CRC_W-1:0] c,
                                                   input logic             d);
        logic fb;
        fb = d ^ c[6];
        return {c[5:3], c[2] ^ fb, c[1:0], fb};
    endfunction

    // Last ex_clk cycle of the current CMD bit.
    assign bit_tick_c = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign crc_next_c = crc7_step(crc_reg, shift_reg[PAYLOAD_W-1]);

    // Frame sequencer; every output is registered and set for the state being entered.
    always_ff @(posedge ex_clk or posedge reset) begin
        if (reset) begin
            state            <= S_IDLE;
            shift_reg        <= '0;
            crc_reg          <= '0;
            crc_sh           <= '0;
            bit_cnt          <= '0;
            div_cnt          <= '0;
            expect_q         <= 1'b0;
            sd_cmd_out       <= 1'b1;
            sd_cmd_oe        <= 1'b0;
            busy             <= 1'b0;
            sd_send_finished <= 1'b0;
            receive_en       <= 1'b0;
            crc_out          <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (send_en) begin
                        shift_reg  <= {2'b01, cmd_index, cmd_arg};
                        expect_q   <= expect_response;
                        crc_reg    <= '0;
                        bit_cnt    <= '0;
                        div_cnt    <= '0;
                        sd_cmd_oe  <= 1'b1;
                        sd_cmd_out <= 1'b0;   // start bit
                        busy       <= 1'b1;
                        state      <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (bit_tick_c) begin
                        div_cnt   <= '0;
                        crc_reg   <= crc_next_c;
                        shift_reg <= {shift_reg[PAYLOAD_W-2:0], 1'b0};
                        if (bit_cnt == CNT_W'(PAYLOAD_W - 1)) begin
                            // CRC is complete with this bit; its MSB goes out next.
                            bit_cnt    <= '0;
                            crc_sh     <= crc_next_c;
                            sd_cmd_out <= crc_next_c[CRC_W-1];
                            state      <= S_CRC;
                        end else begin
                            bit_cnt    <= bit_cnt + CNT_W'(1);
                            sd_cmd_out <= shift_reg[PAYLOAD_W-2];
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                S_CRC: begin
                    if (bit_tick_c) begin
                        div_cnt <= '0;
                        crc_sh  <= {crc_sh[CRC_W-2:0], 1'b0};
                        if (bit_cnt == CNT_W'(CRC_W - 1)) begin
                            bit_cnt    <= '0;
                            sd_cmd_out <= 1'b1;   // end bit
                            state      <= S_STOP;
                        end else begin
                            bit_cnt    <= bit_cnt + CNT_W'(1);
                            sd_cmd_out <= crc_sh[CRC_W-2];
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                S_STOP: begin
                    if (bit_tick_c) begin
                        div_cnt          <= '0;
                        sd_cmd_oe        <= 1'b0;
                        sd_cmd_out       <= 1'b1;
                        sd_send_finished <= 1'b1;
                        receive_en       <= expect_q;
                        crc_out          <= crc_reg;
                        state            <= S_DONE;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                S_DONE: begin
                    // send_en is deliberately not looked at here.
                    sd_send_finished <= 1'b0;
                    receive_en       <= 1'b0;
                    busy             <= 1'b0;
                    state            <= S_IDLE;
                end

                default: begin
                    sd_cmd_oe        <= 1'b0;
                    sd_cmd_out       <= 1'b1;
                    busy             <= 1'b0;
                    sd_send_finished <= 1'b0;
                    receive_en       <= 1'b0;
                    state            <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_send.sv
// tb_sd_cmd_send: self-checking bench for sd_cmd_send.
// Three instances (CLK_DIV = 1, 2, 4) share clock, reset and command inputs;
// each has its own send_en. Expected frames come from a reference model that
// builds the 48-bit frame and gets the CRC7 by polynomial long division.
module tb_sd_cmd_send;

    logic        ex_clk = 1'b0;
    logic        reset;
    logic [2:0]  send_en;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        expect_response;

    logic [2:0]  so, soe, sbusy, sfin, srx;
    logic [6:0]  scrc [3];

    int ncmp = 0;
    int nfail = 0;

    always #5 ex_clk = ~ex_clk;

    sd_cmd_send #(.CLK_DIV(1)) u_d1 (
        .ex_clk(ex_clk), .reset(reset), .send_en(send_en[0]),
        .cmd_index(cmd_index), .cmd_arg(cmd_arg), .expect_response(expect_response),
        .sd_cmd_out(so[0]), .sd_cmd_oe(soe[0]), .busy(sbusy[0]),
        .sd_send_finished(sfin[0]), .receive_en(srx[0]), .crc_out(scrc[0]));

    sd_cmd_send #(.CLK_DIV(2)) u_d2 (
        .ex_clk(ex_clk), .reset(reset), .send_en(send_en[1]),
        .cmd_index(cmd_index), .cmd_arg(cmd_arg), .expect_response(expect_response),
        .sd_cmd_out(so[1]), .sd_cmd_oe(soe[1]), .busy(sbusy[1]),
        .sd_send_finished(sfin[1]), .receive_en(srx[1]), .crc_out(scrc[1]));

    sd_cmd_send #(.CLK_DIV(4)) u_d4 (
        .ex_clk(ex_clk), .reset(reset), .send_en(send_en[2]),
        .cmd_index(cmd_index), .cmd_arg(cmd_arg), .expect_response(expect_response),
        .sd_cmd_out(so[2]), .sd_cmd_oe(soe[2]), .busy(sbusy[2]),
        .sd_send_finished(sfin[2]), .receive_en(srx[2]), .crc_out(scrc[2]));

    function automatic int div_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
    endfunction

    // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1.
    function automatic logic [6:0] ref_crc(input logic [39:0] m);
        logic [46:0] r;
        r = {m, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        return r[6:0];
    endfunction

    function automatic logic [47:0] ref_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] m;
        m = {2'b01, idx, arg};
        return {m, ref_crc(m), 1'b1};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a request to instance k; the next rising edge accepts it.
    task automatic start(input int k, input logic [5:0] idx, input logic [31:0] arg,
                         input logic exp);
        @(negedge ex_clk);
        cmd_index       = idx;
        cmd_arg         = arg;
        expect_response = exp;
        send_en[k]      = 1'b1;
    endtask

    // Watch one frame on instance k, starting from the acceptance edge.
    // mode 0: drop send_en; 1: keep it high; 2: drop it, then re-pulse it and
    // scramble the command inputs mid-frame.
    task automatic monitor(input int k, input logic [47:0] frame, input logic [6:0] crc,
                           input logic exp_rx, input int mode, input string tag);
        int d, last, bit_err, oe_cnt, busy_low, fin_cnt, fin_at, rx_cnt, rx_alone;
        logic [6:0] crc_seen;
        logic fin_out, fin_oe;
        d = div_of(k);
        last = 48 * d + 1;
        bit_err = 0; oe_cnt = 0; busy_low = 0; fin_cnt = 0; fin_at = -1;
        rx_cnt = 0; rx_alone = 0; crc_seen = '0; fin_out = 1'b0; fin_oe = 1'b1;
        for (int c = 1; c <= last; c++) begin
            @(posedge ex_clk);
            #1;
            if (c == 1 && mode != 1) send_en[k] = 1'b0;
            if (mode == 2 && c == 10) begin
                send_en[k] = 1'b1;
                cmd_arg    = $urandom;
                cmd_index  = 6'($urandom);
            end
            if (mode == 2 && c == 12) send_en[k] = 1'b0;
            if (soe[k]) oe_cnt++;
            if (!sbusy[k]) busy_low++;
            if (c < last && (so[k] !== frame[47 - (c - 1) / d] || soe[k] !== 1'b1))
                bit_err++;
            if (sfin[k]) begin
                fin_cnt++;
                fin_at   = c;
                crc_seen = scrc[k];
                fin_out  = so[k];
                fin_oe   = soe[k];
            end
            if (srx[k]) begin
                rx_cnt++;
                if (!sfin[k]) rx_alone++;
            end
        end
        chk({tag, " bits"}, 64'(bit_err), 64'd0);
        chk({tag, " oe_cycles"}, 64'(oe_cnt), 64'(48 * d));
        chk({tag, " busy"}, 64'(busy_low), 64'd0);
        chk({tag, " fin_cycle"}, 64'(fin_at), 64'(last));
        chk({tag, " fin_count"}, 64'(fin_cnt), 64'd1);
        chk({tag, " fin_line"}, {62'd0, fin_oe, fin_out}, 64'b01);
        chk({tag, " rx_count"}, 64'(rx_cnt), 64'(exp_rx));
        chk({tag, " rx_alone"}, 64'(rx_alone), 64'd0);
        chk({tag, " crc_out"}, 64'(crc_seen), 64'(crc));
        // Cycle after the finished pulse: back to idle.
        @(posedge ex_clk);
        #1;
        chk({tag, " post"}, {61'd0, sfin[k], soe[k], sbusy[k]}, 64'd0);
    endtask

    task automatic quiet(input int k, input int n, input string tag);
        int act;
        act = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge ex_clk);
            #1;
            if (soe[k] || sfin[k] || sbusy[k]) act++;
        end
        chk({tag, " quiet"}, 64'(act), 64'd0);
    endtask

    initial begin
        logic [47:0] f;
        send_en = '0; cmd_index = '0; cmd_arg = '0; expect_response = 1'b0;
        reset = 1'b1;
        #1;
        for (int k = 0; k < 3; k++)
            chk($sformatf("reset_state%0d", k),
                {52'd0, so[k], soe[k], sbusy[k], sfin[k], srx[k], scrc[k]},
                {52'd0, 1'b1, 4'b0000, 7'h00});
        repeat (3) @(posedge ex_clk);
        @(negedge ex_clk);
        reset = 1'b0;

        // Reference model sanity against known SD command CRCs.
        chk("model_cmd0", 64'(ref_frame(6'd0, 32'd0)), 64'h40_00000000_95);

        // CMD0 at CLK_DIV=1, no response expected.
        start(0, 6'd0, 32'd0, 1'b0);
        monitor(0, 48'h40_00000000_95, 7'h4A, 1'b0, 0, "cmd0_d1");

        // CMD8 at CLK_DIV=4 with response.
        start(2, 6'd8, 32'h0000_01AA, 1'b1);
        monitor(2, 48'h48_000001AA_87, 7'h43, 1'b1, 0, "cmd8_d4");

        // CMD17 at CLK_DIV=2 with mid-frame disturbance; no second frame.
        start(1, 6'd17, 32'd0, 1'b0);
        monitor(1, 48'h51_00000000_55, 7'h2A, 1'b0, 2, "cmd17_d2");
        quiet(1, 120, "cmd17_d2");

        // Reset at bit 20 of a CLK_DIV=2 frame.
        start(1, 6'd55, 32'h1234_5678, 1'b1);
        @(posedge ex_clk);
        #1;
        send_en[1] = 1'b0;
        repeat (20 * 2) @(posedge ex_clk);
        #1;
        reset = 1'b1;
        #1;
        chk("reset_mid_line", {61'd0, soe[1], so[1], sfin[1]}, 64'b010);
        chk("reset_mid_busy", 64'(sbusy[1]), 64'd0);
        repeat (2) @(posedge ex_clk);
        @(negedge ex_clk);
        reset = 1'b0;
        quiet(1, 100, "after_reset");
        f = ref_frame(6'd55, 32'h1234_5678);
        start(1, 6'd55, 32'h1234_5678, 1'b1);
        monitor(1, f, f[7:1], 1'b1, 0, "resend_d2");

        // Back-to-back with send_en held high at CLK_DIV=1.
        f = ref_frame(6'd41, 32'h8000_0000);
        start(0, 6'd41, 32'h8000_0000, 1'b0);
        monitor(0, f, f[7:1], 1'b0, 1, "b2b_first");
        monitor(0, f, f[7:1], 1'b0, 1, "b2b_second");
        send_en[0] = 1'b0;
        quiet(0, 60, "b2b_end");

        // Random commands on random instances.
        for (int n = 0; n < 8; n++) begin
            int k;
            logic [5:0]  idx;
            logic [31:0] arg;
            logic        ex;
            k   = int'($urandom_range(0, 2));
            idx = 6'($urandom);
            arg = $urandom;
            ex  = 1'($urandom);
            f   = ref_frame(idx, arg);
            start(k, idx, arg, ex);
            monitor(k, f, f[7:1], ex, 0, $sformatf("rand%0d_k%0d", n, k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
